divider_8: RTL

- Sequential unsigned restoring divider: quotient = a / b and remainder = a % b.
- Counterpart to the ripple adder datapath: inverts addition through repeated trial subtraction.
- Sits beside the adder in the arithmetic test set.
- start/busy/done handshake; one quotient bit resolved per clock.

---
 rtl/divider_pkg.sv | 12 +
 rtl/sub_borrow_w.sv | 23 ++
 rtl/divider_8.sv | 103 ++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package divider_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub_borrow_w.sv
// Ripple-borrow subtractor: diff = x - y, bout high when x < y.
module sub_borrow_w #(
    parameter int W = 9
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] diff,
    output logic         bout
);

    logic [W:0] bw;

    assign bw[0] = 1'b0;

    // Each stage mirrors a full adder with borrow in place of carry.
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign diff[i]  = x[i] ^ y[i] ^ bw[i];
        assign bw[i+1]  = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & bw[i]);
    end

    assign bout = bw[W];

endmodule

// File: rtl/divider_8.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
module divider_8
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] b_reg;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;
    logic             accept;
    logic             last_step;

    assign shifted   = {r[WIDTH-1:0], q[WIDTH-1]};
    assign r_next    = borrow ? shifted : trial;
    assign q_next    = {q[WIDTH-2:0], ~borrow};
    assign accept    = start && (state == IDLE || state == DONE);
    assign last_step = (state == RUN) && (count == CW'(1));

    sub_borrow_w #(.W(WIDTH + 1)) u_sub (
        .x   (shifted),
        .y   ({1'b0, b_reg}),
        .diff(trial),
        .bout(borrow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) state_nxt = (b == '0) ? DONE : RUN;
                else       state_nxt = IDLE;
            end
            RUN:     if (count == CW'(1)) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Results only move at completion; a divide-by-zero completes at the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r         <= '0;
            q         <= '0;
            b_reg     <= '0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (accept) begin
            b_reg <= b;
            r     <= '0;
            if (b == '0) begin
                q         <= '0;
                count     <= '0;
                quotient  <= '1;
                remainder <= a;
                div_zero  <= 1'b1;
            end else begin
                q     <= a;
                count <= CW'(WIDTH);
            end
        end else if (state == RUN) begin
            r     <= r_next;
            q     <= q_next;
            count <= count - 1'b1;
            if (last_step) begin
                quotient  <= q_next;
                remainder <= r_next[WIDTH-1:0];
                div_zero  <= 1'b0;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
